reg_file_dump: RTL and testbench

- Read-side master for RegFile: walks an address range on one RegFile read port and streams each register's contents out over a valid/ready handshake.
- Used for debug dumps, context save and testbench checking of architectural state.
- Sits beside RegFile. It drives the read address and consumes the combinational read data. It never writes.

---
 rtl/reg_pkg.sv | 23 ++
 rtl/reg_file_dump_if.sv | 50 +++++
 rtl/reg_file_dump.sv | 145 ++++++++++++++
 tb/tb_reg_file_dump.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// ============================================================================
// Module      : reg_pkg
// Description : Shared types and default sizes for RegFile and its dump
//               master. Contents: FSM state encoding for the dump master,
//               default data width (DEF_W) and address width (DEF_D).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_pkg;

  localparam int DEF_W = 8;  // data path width, matches RegFile
  localparam int DEF_D = 3;  // address width, 2**DEF_D registers

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } dump_state_t;

endpackage

`default_nettype wire

// File: rtl/reg_file_dump_if.sv
// ============================================================================
// Module      : reg_file_dump_if
// Description : Bus bundle between the dump master, its RegFile read port and
//               the downstream consumer.
//   master : dump engine side (drives raddr and the dump output stream)
//   slave  : environment side (control, RegFile read data, dump_ready)
//   start/abort            : dump request / cancel
//   first_addr/last_addr   : inclusive register range, may wrap
//   raddr/rdata            : RegFile read port (combinational data)
//   dump_valid/dump_ready  : output stream handshake
//   dump_data/addr/last    : output word, its source address, final marker
//   busy/done              : dump in progress / one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_file_dump_if
  import reg_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int D = DEF_D
);

  logic         start;
  logic         abort;
  logic [D-1:0] first_addr;
  logic [D-1:0] last_addr;
  logic [D-1:0] raddr;
  logic [W-1:0] rdata;
  logic         dump_valid;
  logic         dump_ready;
  logic [W-1:0] dump_data;
  logic [D-1:0] dump_addr;
  logic         dump_last;
  logic         busy;
  logic         done;

  modport master (
    input  start, abort, first_addr, last_addr, rdata, dump_ready,
    output raddr, dump_valid, dump_data, dump_addr, dump_last, busy, done
  );

  modport slave (
    output start, abort, first_addr, last_addr, rdata, dump_ready,
    input  raddr, dump_valid, dump_data, dump_addr, dump_last, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/reg_file_dump.sv
// ============================================================================
// Module      : reg_file_dump
// Description : Read-side master for RegFile. Walks an inclusive, possibly
//               wrapping, address range on one read port and streams each
//               register over a valid/ready handshake. Never writes.
//   i_clk : clock, all state on posedge
//   i_rst : asynchronous active-high reset
//   bus   : reg_file_dump_if.master (control, read port, output stream)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_dump
  import reg_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int D = DEF_D
) (
  input  wire logic        i_clk,
  input  wire logic        i_rst,
  reg_file_dump_if.master  bus
);

  dump_state_t  r_state;
  dump_state_t  w_next_state;

  logic [D-1:0] r_addr;
  logic [D:0]   r_remaining;   // one extra bit so a full 2**D dump fits
  logic [W-1:0] r_data;
  logic [D-1:0] r_daddr;
  logic         r_valid;
  logic         r_last;
  logic         r_busy;
  logic         r_done;

  logic [D-1:0] w_span;
  logic [D:0]   w_count;
  logic         w_start;
  logic         w_abort;
  logic         w_handshake;
  logic         w_capture;
  logic         w_final_hs;

  // Range length wraps modulo 2**D; last == first-1 yields the full file.
  assign w_span      = bus.last_addr - bus.first_addr;
  assign w_count     = {1'b0, w_span} + {{D{1'b0}}, 1'b1};

  assign w_start     = bus.start && (r_state == IDLE);
  assign w_abort     = bus.abort && (r_state != IDLE);
  assign w_handshake = r_valid && bus.dump_ready;
  // The output slot can take a new word when empty or emptying this cycle.
  assign w_capture   = (r_state == SCAN) && (!r_valid || bus.dump_ready);
  assign w_final_hs  = (r_state == DRAIN) && w_handshake && !bus.abort;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state; abort outranks capture and handshake
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next_state = SCAN;
        end
      end
      SCAN: begin
        if (bus.abort) begin
          w_next_state = IDLE;
        end else if (w_capture && (r_remaining == {{D{1'b0}}, 1'b1})) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          w_next_state = IDLE;
        end else if (w_handshake) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Address walker and output register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_data      <= '0;
      r_daddr     <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_final_hs;
      r_busy <= (w_next_state != IDLE);
      if (w_abort) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        if (w_start) begin
          r_addr      <= bus.first_addr;
          r_remaining <= w_count;
        end
        if (w_capture) begin
          // Rdata is combinational from RegFile for the current r_addr.
          r_data      <= bus.rdata;
          r_daddr     <= r_addr;
          r_valid     <= 1'b1;
          r_last      <= (r_remaining == {{D{1'b0}}, 1'b1});
          r_addr      <= r_addr + {{(D-1){1'b0}}, 1'b1};
          r_remaining <= r_remaining - {{D{1'b0}}, 1'b1};
        end else if (w_handshake) begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
      end
    end
  end

  assign bus.raddr      = r_addr;
  assign bus.dump_valid = r_valid;
  assign bus.dump_data  = r_data;
  assign bus.dump_addr  = r_daddr;
  assign bus.dump_last  = r_last;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_dump.sv
// ============================================================================
// Module      : tb_reg_file_dump
// Description : Directed self-checking bench for reg_file_dump. A small
//               register array stands in for RegFile, preloaded with
//               8'h10 + index, so every expected word is 8'h10 + address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_dump;

  logic       clk;
  logic       rst;
  logic [7:0] regs [8];
  int         n_total;
  int         n_bad;

  reg_file_dump_if #(.W(8), .D(3)) bus ();

  reg_file_dump #(.W(8), .D(3)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // RegFile stand-in: combinational read port
  assign bus.rdata = regs[bus.raddr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_raddr"}, 32'(bus.raddr), 0);
    check({nm, "_valid"}, 32'(bus.dump_valid), 0);
    check({nm, "_data"},  32'(bus.dump_data), 0);
    check({nm, "_daddr"}, 32'(bus.dump_addr), 0);
    check({nm, "_last"},  32'(bus.dump_last), 0);
    check({nm, "_busy"},  32'(bus.busy), 0);
    check({nm, "_done"},  32'(bus.done), 0);
  endtask

  // mode 0: dump_ready held high; mode 1: ready pattern 1,0,0 repeating
  task automatic run_dump(input logic [2:0] first, input logic [2:0] last,
                          input int mode, input string nm);
    logic [2:0] span;
    logic [2:0] ea;
    logic [7:0] hd;
    logic [2:0] ha;
    logic       hl;
    logic       stalled;
    int         count;
    int         k;
    int         cyc;
    span  = last - first;
    count = int'(span) + 1;
    @(negedge clk);
    bus.first_addr = first;
    bus.last_addr  = last;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({nm, "_busy_start"}, 32'(bus.busy), 1);
    check({nm, "_valid_lat"},  32'(bus.dump_valid), 0);
    k = 0; cyc = 0; stalled = 1'b0;
    hd = '0; ha = '0; hl = 1'b0;
    while (k < count && cyc < 200) begin
      bus.dump_ready = (mode == 0) || (cyc % 3 == 1);
      if (bus.dump_valid) begin
        if (stalled) begin
          check({nm, "_hold_data"}, 32'(bus.dump_data), 32'(hd));
          check({nm, "_hold_addr"}, 32'(bus.dump_addr), 32'(ha));
          check({nm, "_hold_last"}, 32'(bus.dump_last), 32'(hl));
        end
        if (bus.dump_ready) begin
          ea = first + 3'(k);
          check($sformatf("%s_data%0d", nm, k), 32'(bus.dump_data), 32'h10 + 32'(ea));
          check($sformatf("%s_addr%0d", nm, k), 32'(bus.dump_addr), 32'(ea));
          check($sformatf("%s_last%0d", nm, k), 32'(bus.dump_last), (k == count - 1) ? 1 : 0);
          k++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hd = bus.dump_data;
          ha = bus.dump_addr;
          hl = bus.dump_last;
        end
      end
      @(negedge clk);
      cyc++;
    end
    check({nm, "_words"}, 32'(k), 32'(count));
    if (mode == 0) begin
      check({nm, "_cycles"}, 32'(cyc), 32'(count + 1));
    end
    check({nm, "_done"},       32'(bus.done), 1);
    check({nm, "_busy_end"},   32'(bus.busy), 0);
    check({nm, "_valid_end"},  32'(bus.dump_valid), 0);
    @(negedge clk);
    check({nm, "_done_pulse"}, 32'(bus.done), 0);
  endtask

  initial begin
    int k;
    int cyc;
    n_total = 0;
    n_bad   = 0;
    for (int i = 0; i < 8; i++) regs[i] = 8'h10 + 8'(i);
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.first_addr = '0;
    bus.last_addr  = '0;
    bus.dump_ready = 1'b1;

    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    run_dump(3'd0, 3'd7, 0, "full");
    run_dump(3'd6, 3'd1, 0, "wrap");
    run_dump(3'd3, 3'd3, 0, "single");
    run_dump(3'd0, 3'd7, 1, "bp");

    // Abort after the third handshake
    @(negedge clk);
    bus.first_addr = 3'd0;
    bus.last_addr  = 3'd7;
    bus.dump_ready = 1'b1;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0; cyc = 0;
    while (k < 3 && cyc < 50) begin
      if (bus.dump_valid) k++;
      @(negedge clk);
      cyc++;
    end
    check("abort_hs", 32'(k), 3);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_valid", 32'(bus.dump_valid), 0);
    check("abort_busy",  32'(bus.busy), 0);
    check("abort_last",  32'(bus.dump_last), 0);
    check("abort_done",  32'(bus.done), 0);
    @(negedge clk);
    check("abort_done2", 32'(bus.done), 0);
    run_dump(3'd5, 3'd6, 0, "post_abort");

    // Stalled dump, ignored re-Start, then async reset between edges
    @(negedge clk);
    bus.first_addr = 3'd0;
    bus.last_addr  = 3'd7;
    bus.dump_ready = 1'b0;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.first_addr = 3'd5;
    bus.last_addr  = 3'd5;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("ign_busy",  32'(bus.busy), 1);
    check("ign_valid", 32'(bus.dump_valid), 1);
    check("ign_addr0", 32'(bus.dump_addr), 0);
    bus.dump_ready = 1'b1;
    @(negedge clk);
    check("ign_addr1", 32'(bus.dump_addr), 1);
    check("ign_data1", 32'(bus.dump_data), 32'h11);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 0);
    run_dump(3'd0, 3'd7, 0, "post_rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
